arith_iter_mul_ctrl: RTL and testbench
======================================

Name: arith_iter_mul_ctrl

Overview:
- Iterative shift-add multiplier controller. Sequences one adder, one left shift, one right shift and an iteration counter per cycle.
- Accepts one operand pair per transaction over a val/rdy request interface. Returns the low p_nbits of the product over a val/rdy response interface.
- Every transaction carries a 1-bit security domain tag. Latency is constant regardless of operand values, so timing carries no operand information.
- Used as a shared multiply resource by the processor datapath.

Parameters:
p_nbits, 32, operand and result width
p_cnt_nbits, 6, iteration counter width; must satisfy 2^p_cnt_nbits > p_nbits

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
req_val  input  1  request valid
req_rdy  output  1  request ready; label {L}
req_domain  input  1  request security domain; label {L}
req_a  input  p_nbits  multiplicand; label {Domain req_domain}
req_b  input  p_nbits  multiplier; label {Domain req_domain}
resp_val  output  1  response valid; label {L}
resp_rdy  input  1  response ready; label {L}
resp_domain  output  1  domain of current response; label {L}
resp_result  output  p_nbits  product mod 2^p_nbits; label {Domain resp_domain}

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high, sampled on the rising edge of clk.
- State registers: FSM states IDLE, CALC, DONE. Internal registers are a_reg, b_reg, acc_reg (all p_nbits), cnt_reg (p_cnt_nbits) and dom_reg (1).
- Reset:
  - FSM goes to IDLE.
  - a_reg, b_reg, acc_reg, cnt_reg and dom_reg clear to 0.
  - While reset is high: req_rdy=0, resp_val=0, resp_domain=0, resp_result=0.
- IDLE:
  - req_rdy=1, resp_val=0.
  - On req_val && req_rdy at edge T: a_reg<=req_a, b_reg<=req_b, dom_reg<=req_domain, acc_reg<=0, cnt_reg<=0, state<=CALC.
- CALC:
  - req_rdy=0, resp_val=0.
  - Each cycle: if b_reg[0], acc_reg<=acc_reg+a_reg (carry-out discarded, wraps mod 2^p_nbits).
  - Each cycle: a_reg<=a_reg<<1, b_reg<=b_reg>>1 (logical), cnt_reg<=cnt_reg+1.
  - When cnt_reg==p_nbits-1, this is the last iteration and state<=DONE.
  - Exactly p_nbits CALC cycles always. No early termination when b_reg reaches 0.
- DONE:
  - resp_val=1, resp_result=acc_reg, resp_domain=dom_reg, req_rdy=0.
  - On resp_rdy, the response handshake completes: state<=IDLE, and acc_reg and dom_reg scrub to 0.
  - While resp_rdy=0, state, resp_result and resp_domain hold stable.
- Latency: request accepted at edge T gives resp_val=1 from cycle T+p_nbits+1. With p_nbits=32, resp_val first asserts 33 cycles after acceptance.
- Throughput: at most one transaction per p_nbits+2 cycles. No request is accepted in CALC or DONE. req_val in those states is ignored and does not disturb state.
- Output gating: outside DONE, resp_result=0 and resp_domain=0. No stale data or domain is ever visible.
- req_rdy and resp_val are pure functions of state (Moore outputs), independent of req_val and resp_rdy combinationally.
- reset during CALC or DONE: abandon the transaction, go to IDLE at the next edge, no response, all registers cleared.
- Simultaneous reset and handshake: reset wins; the handshake is not performed.

Test Plan:
- Reset, then req a=3, b=5, domain=0, resp_rdy=1 -> req_rdy=0 during CALC; resp_val=1 exactly 33 cycles after accept; resp_result=15, resp_domain=0; IDLE next cycle.
- a=0xFFFFFFFF, b=0xFFFFFFFF, domain=1 -> resp_result=0x00000001, resp_domain=1. Then a=0x12345678, b=0 -> resp_result=0. Both return at exactly 33-cycle latency (constant time).
- Backpressure: a=7, b=6, resp_rdy=0 for 10 cycles after resp_val -> resp_val, resp_result=42 and resp_domain hold stable; req_val=1 with other operands is ignored (req_rdy=0); resp_rdy=1 completes and returns to IDLE.
- Back-to-back: domain 1 (a=2, b=9) then domain 0 (a=4, b=4) -> results 18 then 16 with correct domains; resp_result=0 and resp_domain=0 on every cycle outside DONE.
- Reset asserted 10 cycles into CALC -> next cycle IDLE, req_rdy=1, no resp_val ever asserted for the aborted op; subsequent a=10, b=10 returns 100.
- Wrap: a=0x80000000, b=2 -> resp_result=0x00000000; a=0x40000000, b=3 -> 0xC0000000.

Source files
------------

// File: rtl/arith_iter_mul_ctrl.sv
// Iterative shift-add multiplier controller.
// One operand pair is accepted per transaction. The low p_nbits of the
// product are returned after a fixed number of cycles. Each transaction
// carries a 1-bit security domain tag. The iteration count never depends
// on operand values, so the response timing reveals nothing about the data.
// The result and domain outputs read as zero whenever no response is being
// offered, so no stale product or domain tag can be observed.

module arith_iter_mul_ctrl #(
    parameter int unsigned p_nbits     = 32,
    parameter int unsigned p_cnt_nbits = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_val,
    output logic               req_rdy,
    input  logic               req_domain,
    input  logic [p_nbits-1:0] req_a,
    input  logic [p_nbits-1:0] req_b,
    output logic               resp_val,
    input  logic               resp_rdy,
    output logic               resp_domain,
    output logic [p_nbits-1:0] resp_result
);

    // Counter value during the final CALC iteration.
    localparam logic [p_cnt_nbits-1:0] CNT_LAST = p_cnt_nbits'(p_nbits - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [p_nbits-1:0]     a_q, a_d;
    logic [p_nbits-1:0]     b_q, b_d;
    logic [p_nbits-1:0]     acc_q, acc_d;
    logic [p_cnt_nbits-1:0] cnt_q, cnt_d;
    logic                   dom_q, dom_d;

    // Output registers. They are loaded with the values that belong to the
    // state being entered, so the ports behave as Moore outputs of state_q.
    logic                   req_rdy_q, req_rdy_d;
    logic                   resp_val_q, resp_val_d;
    logic                   resp_dom_q, resp_dom_d;
    logic [p_nbits-1:0]     resp_result_q, resp_result_d;

    // Next-state and datapath: one add, one left shift, one right shift
    // and one counter increment per CALC cycle.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        dom_d   = dom_q;

        case (state_q)
            ST_IDLE: begin
                // req_rdy is high throughout IDLE, so req_val alone completes the handshake.
                if (req_val) begin
                    a_d     = req_a;
                    b_d     = req_b;
                    dom_d   = req_domain;
                    acc_d   = {p_nbits{1'b0}};
                    cnt_d   = {p_cnt_nbits{1'b0}};
                    state_d = ST_CALC;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_CALC: begin
                // The carry-out is dropped, so the accumulator wraps modulo 2^p_nbits.
                if (b_q[0]) begin
                    acc_d = acc_q + a_q;
                end else begin
                    acc_d = acc_q;
                end
                a_d   = {a_q[p_nbits-2:0], 1'b0};
                b_d   = {1'b0, b_q[p_nbits-1:1]};
                cnt_d = cnt_q + p_cnt_nbits'(1);
                // The loop always runs p_nbits iterations. It does not stop
                // early when b_q reaches zero, which keeps the latency constant.
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_CALC;
                end
            end

            ST_DONE: begin
                if (resp_rdy) begin
                    // Clear the product and domain once the response has been delivered.
                    acc_d   = {p_nbits{1'b0}};
                    dom_d   = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end

            default: begin
                // Recovery from an illegal encoding: clear everything and return to IDLE.
                a_d     = {p_nbits{1'b0}};
                b_d     = {p_nbits{1'b0}};
                acc_d   = {p_nbits{1'b0}};
                cnt_d   = {p_cnt_nbits{1'b0}};
                dom_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output values for the state being entered. Outside DONE the result
    // and domain are forced to zero.
    always_comb begin
        req_rdy_d     = 1'b0;
        resp_val_d    = 1'b0;
        resp_dom_d    = 1'b0;
        resp_result_d = {p_nbits{1'b0}};

        case (state_d)
            ST_IDLE: begin
                req_rdy_d = 1'b1;
            end
            ST_CALC: begin
                req_rdy_d = 1'b0;
            end
            ST_DONE: begin
                resp_val_d    = 1'b1;
                resp_dom_d    = dom_d;
                resp_result_d = acc_d;
            end
            default: begin
                req_rdy_d = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers with synchronous active-high reset.
    // Reset abandons any transaction in flight and takes priority over a handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            a_q           <= {p_nbits{1'b0}};
            b_q           <= {p_nbits{1'b0}};
            acc_q         <= {p_nbits{1'b0}};
            cnt_q         <= {p_cnt_nbits{1'b0}};
            dom_q         <= 1'b0;
            // Reset leaves the block in IDLE, so the ready register is set.
            // The port itself stays low while reset is asserted (see below).
            req_rdy_q     <= 1'b1;
            resp_val_q    <= 1'b0;
            resp_dom_q    <= 1'b0;
            resp_result_q <= {p_nbits{1'b0}};
        end else begin
            state_q       <= state_d;
            a_q           <= a_d;
            b_q           <= b_d;
            acc_q         <= acc_d;
            cnt_q         <= cnt_d;
            dom_q         <= dom_d;
            req_rdy_q     <= req_rdy_d;
            resp_val_q    <= resp_val_d;
            resp_dom_q    <= resp_dom_d;
            resp_result_q <= resp_result_d;
        end
    end

    // Gating with reset keeps every output low while reset is asserted,
    // so no handshake can complete during reset.
    assign req_rdy     = req_rdy_q  & ~reset;
    assign resp_val    = resp_val_q & ~reset;
    assign resp_domain = resp_dom_q & ~reset;
    assign resp_result = resp_result_q & {p_nbits{~reset}};

endmodule

// File: tb/tb_arith_iter_mul_ctrl.sv
// Scoreboard bench for arith_iter_mul_ctrl.
// Expected products come from plain multiplication truncated to 32 bits.
// Expected handshake timing comes from a transaction-level model:
//   - The request is accepted at posedge T.
//   - The response is offered from the period that begins at posedge T+32,
//     i.e. p_nbits+1 cycles counted from the accepting cycle.
//   - The block is busy until the response handshake completes.

module tb_arith_iter_mul_ctrl;

    localparam int NB = 32;

    typedef struct {
        logic [31:0] res;
        logic        dom;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_val = 1'b0;
    logic        req_rdy;
    logic        req_domain = 1'b0;
    logic [31:0] req_a = 32'd0;
    logic [31:0] req_b = 32'd0;
    logic        resp_val;
    logic        resp_rdy = 1'b1;
    logic        resp_domain;
    logic [31:0] resp_result;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;      // number of posedges so far
    int   m_acc = 0;    // value of cyc at the accepting edge
    bit   m_busy = 1'b0;
    exp_t sb_q[$];

    arith_iter_mul_ctrl #(.p_nbits(32), .p_cnt_nbits(6)) dut (
        .clk(clk),
        .reset(reset),
        .req_val(req_val),
        .req_rdy(req_rdy),
        .req_domain(req_domain),
        .req_a(req_a),
        .req_b(req_b),
        .resp_val(resp_val),
        .resp_rdy(resp_rdy),
        .resp_domain(resp_domain),
        .resp_result(resp_result)
    );

    always #5 clk = ~clk;

    // Compare one value against its expectation and count the comparison.
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h cyc=%0d", name, act, exp, cyc);
        end
    endtask

    // Transaction-level reference model. The product is computed by plain
    // multiplication. The block is idle -> busy on accept, and
    // busy -> idle on the response handshake.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            m_busy <= 1'b0;
            sb_q.delete();
        end else if (!m_busy) begin
            if (req_val) begin
                m_busy <= 1'b1;
                m_acc  <= cyc;
                sb_q.push_back('{res: req_a * req_b, dom: req_domain});
            end
        end else if (((cyc - m_acc) >= NB + 1) && resp_rdy) begin
            m_busy <= 1'b0;
        end
    end

    logic exp_rdy;
    logic exp_val;
    assign exp_rdy = !reset && !m_busy;
    assign exp_val = !reset && m_busy && ((cyc - m_acc) >= NB + 1);

    // Monitor, sampled on the falling edge away from the active edge.
    // It checks the handshake signals every cycle. While a response is
    // offered it checks the payload against the scoreboard head; otherwise
    // it checks that the payload outputs read as zero.
    always @(negedge clk) begin
        chk("req_rdy", {31'd0, req_rdy}, {31'd0, exp_rdy});
        chk("resp_val", {31'd0, resp_val}, {31'd0, exp_val});
        if (exp_val) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_empty actual=resp_val expected=no_response cyc=%0d", cyc);
            end else begin
                chk("resp_result", resp_result, sb_q[0].res);
                chk("resp_domain", {31'd0, resp_domain}, {31'd0, sb_q[0].dom});
                if (resp_rdy) begin
                    void'(sb_q.pop_front());
                end
            end
        end else begin
            chk("gated_result", resp_result, 32'd0);
            chk("gated_domain", {31'd0, resp_domain}, 32'd0);
        end
    end

    // Present one request and hold it until the DUT accepts it (bounded wait).
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic d);
        int n;
        n = 0;
        req_a      = a;
        req_b      = b;
        req_domain = d;
        req_val    = 1'b1;
        @(negedge clk);
        while (!req_rdy && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 200) begin
            failures++;
            $display("FAIL send_timeout actual=no_accept expected=accept cyc=%0d", cyc);
        end
        @(posedge clk);
        #1;
        req_val    = 1'b0;
        req_a      = 32'd0;
        req_b      = 32'd0;
        req_domain = 1'b0;
    endtask

    // Run until the scoreboard is empty and the DUT is idle again.
    // With rnd set, resp_rdy is randomised each cycle.
    task automatic drain(input bit rnd);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || !req_rdy) && n < 400) begin
            @(posedge clk);
            #1;
            resp_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            n++;
        end
        checks++;
        if (n >= 400) begin
            failures++;
            $display("FAIL drain_timeout actual=busy expected=idle cyc=%0d", cyc);
        end
        resp_rdy = 1'b1;
    endtask

    // Wait for resp_val to rise (bounded wait).
    task automatic wait_val();
        int n;
        n = 0;
        @(negedge clk);
        while (!resp_val && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 100) begin
            failures++;
            $display("FAIL wait_val_timeout actual=0 expected=1 cyc=%0d", cyc);
        end
    endtask

    // Watchdog so that the run always reaches the summary line.
    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog actual=running expected=finished cyc=%0d", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Directed scenarios followed by a randomised phase.
    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Basic product, constant latency, return to IDLE.
        send(32'd3, 32'd5, 1'b0);
        drain(1'b0);

        // Wrapping full-scale product, then a zero multiplier.
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        drain(1'b0);
        send(32'h1234_5678, 32'h0000_0000, 1'b0);
        drain(1'b0);

        // Backpressure: hold the response while unrelated requests are offered.
        resp_rdy = 1'b0;
        send(32'd7, 32'd6, 1'b0);
        wait_val();
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            req_val    = 1'b1;
            req_a      = 32'd99;
            req_b      = 32'd77;
            req_domain = 1'b1;
        end
        req_val = 1'b0;
        drain(1'b0);

        // Back-to-back transactions from different domains.
        send(32'd2, 32'd9, 1'b1);
        send(32'd4, 32'd4, 1'b0);
        drain(1'b0);

        // Abort during CALC: no response may appear for the aborted operation.
        send(32'd1234, 32'd5678, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        send(32'd10, 32'd10, 1'b0);
        drain(1'b0);

        // Wrap cases.
        send(32'h8000_0000, 32'd2, 1'b0);
        drain(1'b0);
        send(32'h4000_0000, 32'd3, 1'b1);
        drain(1'b0);

        // Random operands (with some edge-value mixes) and random response backpressure.
        for (int t = 0; t < 24; t++) begin
            ra = $urandom();
            rb = $urandom();
            case ($urandom_range(0, 3))
                0: rb = 32'($urandom_range(0, 15));
                1: ra = 32'hFFFF_FFFF;
                2: rb = 32'h8000_0001;
                default: ra = $urandom();
            endcase
            send(ra, rb, 1'($urandom_range(0, 1)));
            drain(1'b1);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        repeat (3) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
